// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST engine for a single SRAM behind the BIST/functional mux.
// Issues one access per cycle, compares reads one cycle later, and reports done/pass/error count.
module mbist_march_ctrl #(
    parameter int                        BIST_ADDR_WD    = 9,
    parameter int                        BIST_DATA_WD    = 32,
    parameter logic [BIST_ADDR_WD-1:0]   BIST_ADDR_START = 9'h000,
    parameter logic [BIST_ADDR_WD-1:0]   BIST_ADDR_END   = 9'h1F8,
    parameter logic [BIST_DATA_WD-1:0]   BIST_DATA_PAT   = 32'h0000_0000,
    parameter int                        BIST_MAX_ERR    = 4,
    parameter int                        BIST_ERR_WD     = 4
) (
    input  logic                    bist_clk,
    input  logic                    rst,
    input  logic                    bist_run,
    output logic                    bist_en,
    output logic [BIST_ADDR_WD-1:0] bist_addr,
    output logic [BIST_DATA_WD-1:0] bist_wdata,
    output logic                    bist_wr,
    output logic                    bist_rd,
    input  logic [BIST_DATA_WD-1:0] bist_rdata,
    output logic                    bist_error,
    output logic [BIST_ADDR_WD-1:0] bist_error_addr,
    input  logic                    bist_correct,
    output logic                    bist_done,
    output logic                    bist_pass,
    output logic [BIST_ERR_WD-1:0]  bist_err_cnt,
    output logic                    bist_correct_seen
);
    localparam logic [BIST_DATA_WD-1:0] W0      = BIST_DATA_PAT;
    localparam logic [BIST_DATA_WD-1:0] W1      = ~BIST_DATA_PAT;
    localparam logic [BIST_ERR_WD-1:0]  MAX_ERR = BIST_ERR_WD'(BIST_MAX_ERR);

    typedef enum logic [2:0] {IDLE, MARCH_RD, MARCH_WR, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d, elem_nxt;
    logic [BIST_ADDR_WD-1:0] addr_q, addr_d, err_addr_q, err_addr_d, cmp_addr_q, cmp_addr_d;
    logic [BIST_DATA_WD-1:0] wdata_q, wdata_d, cmp_exp_q, cmp_exp_d;
    logic [BIST_ERR_WD-1:0]  cnt_q, cnt_d, cnt_inc;
    logic en_q, en_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic done_q, done_d, pass_q, pass_d, cs_q, cs_d, cmp_vld_q, cmp_vld_d;
    logic up, last, mis;

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        pass_d     = pass_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        cmp_vld_d  = 1'b0;
        cmp_exp_d  = cmp_exp_q;
        cmp_addr_d = cmp_addr_q;

        up       = elem_q < 3'd3;
        last     = up ? (addr_q == BIST_ADDR_END) : (addr_q == BIST_ADDR_START);
        elem_nxt = elem_q + 3'd1;
        mis      = cmp_vld_q && (bist_rdata != cmp_exp_q);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + BIST_ERR_WD'(1);

        case (state_q)
            IDLE: begin
                if (bist_run) begin
                    state_d = MARCH_WR;
                    elem_d  = 3'd0;
                    addr_d  = BIST_ADDR_START;
                    wdata_d = W0;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                end
            end
            MARCH_RD, MARCH_WR: begin
                if (bist_correct) cs_d = 1'b1;
                if (state_q == MARCH_RD) begin
                    cmp_vld_d  = 1'b1;
                    cmp_exp_d  = (elem_q == 3'd2 || elem_q == 3'd4) ? W1 : W0;
                    cmp_addr_d = addr_q;
                end
                if (state_q == MARCH_RD && elem_q != 3'd5) begin
                    state_d = MARCH_WR;
                    wdata_d = (elem_q == 3'd1 || elem_q == 3'd3) ? W1 : W0;
                end else if (last) begin
                    if (elem_q == 3'd5) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = MARCH_RD;
                        elem_d  = elem_nxt;
                        addr_d  = (elem_nxt < 3'd3) ? BIST_ADDR_START : BIST_ADDR_END;
                    end
                end else begin
                    state_d = (elem_q == 3'd0) ? MARCH_WR : MARCH_RD;
                    addr_d  = up ? addr_q + BIST_ADDR_WD'(1) : addr_q - BIST_ADDR_WD'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    if (!bist_run) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Compare the read issued last cycle; an overflow of the budget ends the test now.
        if (mis) begin
            err_d      = 1'b1;
            err_addr_d = cmp_addr_q;
            cnt_d      = cnt_inc;
            if (cnt_inc > MAX_ERR) begin
                state_d   = DONE;
                cmp_vld_d = 1'b0;
            end
        end
        if (state_d == DONE && state_q != DONE) pass_d = (cnt_d <= MAX_ERR);

        if (!bist_run && (state_q == MARCH_RD || state_q == MARCH_WR || state_q == DRAIN)) begin
            state_d    = IDLE;
            err_d      = 1'b0;
            err_addr_d = err_addr_q;
            cnt_d      = cnt_q;
            cmp_vld_d  = 1'b0;
        end

        done_d = (state_d == DONE);
        if (state_d != DONE) pass_d = 1'b0;
        en_d = (state_d == MARCH_RD) || (state_d == MARCH_WR) || (state_d == DRAIN);
        rd_d = (state_d == MARCH_RD);
        wr_d = (state_d == MARCH_WR);
    end

    always_ff @(posedge bist_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            elem_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            en_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_exp_q  <= '0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            en_q       <= en_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_exp_q  <= cmp_exp_d;
            cmp_addr_q <= cmp_addr_d;
        end
    end

    assign bist_en           = en_q;
    assign bist_addr         = addr_q;
    assign bist_wdata        = wdata_q;
    assign bist_wr           = wr_q;
    assign bist_rd           = rd_q;
    assign bist_error        = err_q;
    assign bist_error_addr   = err_addr_q;
    assign bist_done         = done_q;
    assign bist_pass         = pass_q;
    assign bist_err_cnt      = cnt_q;
    assign bist_correct_seen = cs_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench: two controllers (4- and 8-address windows) over a synchronous memory model with stuck-at faults.
module tb_mbist_march_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run1, run2, corr1, corr2;
    logic       en1, rd1, wr1, err1, done1, pass1, cs1;
    logic       en2, rd2, wr2, err2, done2, pass2, cs2;
    logic [3:0] addr1, eaddr1, cnt1, addr2, eaddr2, cnt2;
    logic [7:0] wd1, rdata1, wd2, rdata2;

    logic [7:0] mem1 [16], sa1_1 [16], sa0_1 [16];
    logic [7:0] mem2 [16], sa0_2 [16];

    typedef struct packed {logic rd; logic wr; logic [3:0] addr; logic [7:0] wd;} acc_t;
    acc_t       trace [$];
    logic [3:0] errq1 [$], errq2 [$];
    int         overlap, post2;
    int         checks = 0, errors = 0;

    mbist_march_ctrl #(.BIST_ADDR_WD(4), .BIST_DATA_WD(8), .BIST_ADDR_START(4'h0),
        .BIST_ADDR_END(4'h3), .BIST_DATA_PAT(8'h00), .BIST_MAX_ERR(4), .BIST_ERR_WD(4)) dut1 (
        .bist_clk(clk), .rst(rst), .bist_run(run1), .bist_en(en1), .bist_addr(addr1),
        .bist_wdata(wd1), .bist_wr(wr1), .bist_rd(rd1), .bist_rdata(rdata1), .bist_error(err1),
        .bist_error_addr(eaddr1), .bist_correct(corr1), .bist_done(done1), .bist_pass(pass1),
        .bist_err_cnt(cnt1), .bist_correct_seen(cs1));

    mbist_march_ctrl #(.BIST_ADDR_WD(4), .BIST_DATA_WD(8), .BIST_ADDR_START(4'h0),
        .BIST_ADDR_END(4'h7), .BIST_DATA_PAT(8'h00), .BIST_MAX_ERR(4), .BIST_ERR_WD(4)) dut2 (
        .bist_clk(clk), .rst(rst), .bist_run(run2), .bist_en(en2), .bist_addr(addr2),
        .bist_wdata(wd2), .bist_wr(wr2), .bist_rd(rd2), .bist_rdata(rdata2), .bist_error(err2),
        .bist_error_addr(eaddr2), .bist_correct(corr2), .bist_done(done2), .bist_pass(pass2),
        .bist_err_cnt(cnt2), .bist_correct_seen(cs2));

    initial begin
        rdata1 = 8'h00;
        rdata2 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            sa1_1[i] = 8'h00; sa0_1[i] = 8'h00; sa0_2[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (wr1) mem1[addr1] <= wd1;
        if (rd1) rdata1 <= (mem1[addr1] | sa1_1[addr1]) & ~sa0_1[addr1];
        if (wr2) mem2[addr2] <= wd2;
        if (rd2) rdata2 <= mem2[addr2] & ~sa0_2[addr2];
    end

    always @(negedge clk) begin
        if (rd1 || wr1) trace.push_back({rd1, wr1, addr1, wr1 ? wd1 : 8'h00});
        if (rd1 && wr1) overlap++;
        if (err1) errq1.push_back(eaddr1);
        if (err2) errq2.push_back(eaddr2);
        if (done2 && (rd2 || wr2)) post2++;
    end

    task automatic test_reset();
        rst = 1'b1; run1 = 1'b0; run2 = 1'b0; corr1 = 1'b0; corr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({en1, rd1, wr1, err1, done1, pass1, cs1, addr1, eaddr1, wd1, cnt1} !== '0) begin
            errors++; $display("FAIL reset_dut1 got %h want 0", {en1, rd1, wr1, err1, done1, pass1, cs1, addr1, eaddr1, wd1, cnt1});
        end
        checks++;
        if ({en2, rd2, wr2, err2, done2, pass2, cs2, addr2, eaddr2, wd2, cnt2} !== '0) begin
            errors++; $display("FAIL reset_dut2 got %h want 0", {en2, rd2, wr2, err2, done2, pass2, cs2, addr2, eaddr2, wd2, cnt2});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clean();
        acc_t exp_q [$];
        int   n = 0, bad = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 4; i++) begin
                logic [3:0] a;
                a = (e < 3) ? 4'(i) : 4'(3 - i);
                if (e != 0) exp_q.push_back({1'b1, 1'b0, a, 8'h00});
                if (e != 5) exp_q.push_back({1'b0, 1'b1, a, (e == 1 || e == 3) ? 8'hFF : 8'h00});
            end
        trace.delete(); errq1.delete(); overlap = 0;
        run1 = 1'b1;
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n != 42) begin errors++; $display("FAIL clean_latency got %0d want 42", n); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL clean_pass got %b want 1", pass1); end
        checks++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL clean_cnt got %0d want 0", cnt1); end
        checks++; if (errq1.size() != 0) begin errors++; $display("FAIL clean_no_error got %0d pulses want 0", errq1.size()); end
        checks++; if (en1 !== 1'b0) begin errors++; $display("FAIL clean_en_done got %b want 0", en1); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL clean_rd_wr_overlap got %0d want 0", overlap); end
        checks++;
        if (trace.size() != exp_q.size()) begin
            errors++; $display("FAIL clean_trace_len got %0d want %0d", trace.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (trace[i] !== exp_q[i]) bad++;
            if (bad != 0) begin errors++; $display("FAIL clean_trace_order got %0d wrong entries want 0", bad); end
        end
        run1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done1, pass1, en1} !== 3'b000) begin errors++; $display("FAIL clean_idle got %b want 000", {done1, pass1, en1}); end
    endtask

    task automatic test_stuck1();
        int n = 0, bad = 0;
        sa1_1[2] = 8'h01;
        errq1.delete();
        run1 = 1'b1;
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n != 42) begin errors++; $display("FAIL sa1_latency got %0d want 42", n); end
        checks++; if (errq1.size() != 3) begin errors++; $display("FAIL sa1_pulses got %0d want 3", errq1.size()); end
        foreach (errq1[i]) if (errq1[i] !== 4'd2) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL sa1_err_addr got %0d wrong want 0", bad); end
        checks++; if (cnt1 !== 4'd3) begin errors++; $display("FAIL sa1_cnt got %0d want 3", cnt1); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL sa1_pass got %b want 1", pass1); end
        run1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int npulse;
        run1 = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        checks++;
        if ({rd1, wr1, addr1, wd1, cnt1} !== {1'b0, 1'b1, 4'd2, 8'hFF, 4'd1}) begin
            errors++; $display("FAIL abort_mid_e3 got %h want %h", {rd1, wr1, addr1, wd1, cnt1}, {1'b0, 1'b1, 4'd2, 8'hFF, 4'd1});
        end
        npulse = errq1.size();
        run1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({en1, done1, rd1, wr1} !== 4'b0000) begin errors++; $display("FAIL abort_idle got %b want 0000", {en1, done1, rd1, wr1}); end
        @(posedge clk); #1;
        checks++; if (errq1.size() != npulse) begin errors++; $display("FAIL abort_discard got %0d pulses want %0d", errq1.size(), npulse); end
        checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL abort_cnt_hold got %0d want 1", cnt1); end
        run1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cnt1, en1, wr1, rd1, addr1, wd1} !== {4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00}) begin
            errors++; $display("FAIL abort_restart got %h want %h", {cnt1, en1, wr1, rd1, addr1, wd1}, {4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00});
        end
        run1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        sa1_1[2] = 8'h00;
        run1 = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++; if ({en1, rd1} !== 2'b11) begin errors++; $display("FAIL rstmid_in_e2 got %b want 11", {en1, rd1}); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({en1, rd1, wr1, err1, done1, pass1, cs1, addr1, eaddr1, wd1, cnt1} !== '0) begin
            errors++; $display("FAIL rstmid_clear got %h want 0", {en1, rd1, wr1, err1, done1, pass1, cs1, addr1, eaddr1, wd1, cnt1});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({en1, wr1, rd1, addr1, wd1} !== {1'b1, 1'b1, 1'b0, 4'd0, 8'h00}) begin
            errors++; $display("FAIL rstmid_restart got %h want %h", {en1, wr1, rd1, addr1, wd1}, {1'b1, 1'b1, 1'b0, 4'd0, 8'h00});
        end
        run1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_correct();
        int n = 0;
        run1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL corr_before got %b want 0", cs1); end
        corr1 = 1'b1;
        @(posedge clk); #1;
        corr1 = 1'b0;
        checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL corr_set got %b want 1", cs1); end
        while (!done1 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if ({done1, cs1} !== 2'b11) begin errors++; $display("FAIL corr_done got %b want 11", {done1, cs1}); end
        run1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (cs1 !== 1'b1) begin errors++; $display("FAIL corr_idle_hold got %b want 1", cs1); end
        run1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL corr_restart_clear got %b want 0", cs1); end
        run1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int n = 0, bad = 0;
        for (int a = 0; a < 6; a++) sa0_2[a] = 8'hFF;
        errq2.delete(); post2 = 0;
        run2 = 1'b1;
        while (!done2 && n < 300) begin @(posedge clk); #1; n++; end
        checks++; if (n != 35) begin errors++; $display("FAIL ovf_latency got %0d want 35", n); end
        checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL ovf_pass got %b want 0", pass2); end
        checks++; if (cnt2 !== 4'd5) begin errors++; $display("FAIL ovf_cnt got %0d want 5", cnt2); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (errq2.size() != 5) begin errors++; $display("FAIL ovf_pulses got %0d want 5", errq2.size()); end
        foreach (errq2[i]) if (errq2[i] !== 4'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ovf_err_addr got %0d wrong want 0", bad); end
        checks++;
        if ({post2 != 0, en2, rd2, wr2, done2} !== 5'b00001) begin
            errors++; $display("FAIL ovf_quiet got %b want 00001", {post2 != 0, en2, rd2, wr2, done2});
        end
        run2 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck1();
        test_abort();
        test_reset_mid();
        test_correct();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Memory BIST engine for one SRAM instance; it sits on the BIST side of the per-memory BIST/functional mux.
- Runs a March C- sequence over a parameterised address window and drives bist_en, address, data, read and write controls.
- Compares read data against expected values and pulses error/address towards the repair-address logic, which sits behind the mux.
- Reports done, pass and error count to the BIST register block.

Parameters:
- BIST_ADDR_WD, 9, address width.
- BIST_DATA_WD, 32, data width.
- BIST_ADDR_START, 9'h000, first tested address.
- BIST_ADDR_END, 9'h1F8, last tested address (inclusive). Spare rows above it are not marched.
- BIST_DATA_PAT, 32'h0000_0000, background written as "0"; "1" is its bitwise inverse.
- BIST_MAX_ERR, 4, repairable error budget. Must fit in BIST_ERR_WD.
- BIST_ERR_WD, 4, error counter width.

Ports:
- bist_clk  in  1  BIST clock.
- rst  in  1  Reset, synchronous, active-high.
- bist_run  in  1  Level start/enable. Deassertion aborts the test.
- bist_en  out  1  Mux select; high while a test is active.
- bist_addr  out  BIST_ADDR_WD  Memory address.
- bist_wdata  out  BIST_DATA_WD  Write data.
- bist_wr  out  1  Write strobe, one cycle per write.
- bist_rd  out  1  Read strobe, one cycle per read.
- bist_rdata  in  BIST_DATA_WD  Memory read data, valid the cycle after bist_rd.
- bist_error  out  1  One-cycle pulse on a mismatch.
- bist_error_addr  out  BIST_ADDR_WD  Address of the mismatched read, valid with bist_error.
- bist_correct  in  1  Repair logic reports the current address was remapped.
- bist_done  out  1  Test finished (pass or fail). Sticky until bist_run is low.
- bist_pass  out  1  Valid with bist_done.
- bist_err_cnt  out  BIST_ERR_WD  Mismatches counted. Saturates at the all-ones value.
- bist_correct_seen  out  1  Sticky: bist_correct was sampled high during the test.

Behaviour:
- Reset (rst=1 at a bist_clk edge) sets the state to IDLE and clears every output to 0. Pipeline and counter registers also clear.
- Reset has priority over everything, including mid-test.
- March elements, with W0=BIST_DATA_PAT and W1=~BIST_DATA_PAT:
  - E0 up (w0)
  - E1 up (r0,w1)
  - E2 up (r1,w0)
  - E3 down (r0,w1)
  - E4 down (r1,w0)
  - E5 down (r0)
- "Up" runs START to END; "down" runs END to START, both stepping by 1 per address.
- States: IDLE, MARCH_RD, MARCH_WR, DRAIN, DONE.
  - IDLE to MARCH: when bist_run=1. The first cycle is E0's write at START.
  - Each access takes one cycle.
  - r,w elements alternate RD then WR at the same address, then the address steps.
  - E0 is WR only; E5 is RD only.
  - After the last address of an element, the element index advances and the address loads START (up) or END (down) with no idle cycle.
  - After E5's final read, go to DRAIN for one cycle so the last compare completes, then go to DONE.
- Test length: N=END-START+1. Accesses total 10N cycles, plus 1 DRAIN cycle; bist_done rises on the following edge.
- bist_en is 1 in MARCH and DRAIN, and 0 in IDLE and DONE.
- bist_rd and bist_wr are never high together. Both are 0 outside MARCH.
- Compare pipeline:
  - Each read registers the expected data and the address.
  - On the next cycle, if bist_rdata != expected: bist_error=1 for that cycle, bist_error_addr=registered address, and bist_err_cnt increments (saturating).
- Fail:
  - If a mismatch makes bist_err_cnt > BIST_MAX_ERR, go to DONE at the next edge with bist_pass=0.
  - The remaining march is skipped and no further accesses are issued.
- Pass: on normal completion, bist_pass=1 iff bist_err_cnt <= BIST_MAX_ERR.
- DONE: hold bist_done, bist_pass and bist_err_cnt until bist_run=0, then go to IDLE. In IDLE, bist_done and bist_pass clear; bist_err_cnt holds until the next start.
- Start from IDLE clears bist_err_cnt and bist_correct_seen.
- bist_run=0 during MARCH/DRAIN aborts to IDLE at the next edge:
  - bist_en=0, bist_done=0.
  - Any pending compare is discarded with no error pulse.
- bist_correct is sampled every MARCH cycle and ORed into bist_correct_seen.
- Mismatches are not de-duplicated: the same failing address can pulse repeatedly, and address remapping is the repair logic's concern.

Test Plan:
- Clean run (ADDR_WD=4, START=0, END=3, PAT=0, ideal memory model) -> bist_done at cycle 42 after start, bist_pass=1, bist_err_cnt=0, no bist_error. Access order: 4 w0, then (r0,w1) at 0..3, ..., r0 at 3..0.
- Stuck-at-1 bit0 at addr 2 -> bist_error pulses with addr 2 in E1, E3 and E5 (3 pulses). bist_err_cnt=3, bist_pass=1 with MAX_ERR=4.
- Stuck-at-0 on all bits of 6 addresses, MAX_ERR=4 -> the 5th mismatch leads to DONE next cycle, bist_pass=0, no bist_wr/bist_rd afterwards.
- Drop bist_run in the middle of E3 -> bist_en=0 next cycle, state IDLE, bist_done=0. Restarting clears bist_err_cnt and reruns from E0 at START.
- Assert rst during E2 with bist_run held high -> all outputs 0 after the edge, then a fresh test starts on the following cycle.
- Drive bist_correct=1 for one cycle mid-test -> bist_correct_seen=1 and stays high through DONE. It clears on the next start.
